// File: rtl/ahb_pkg.sv
// Shared AHB-lite types for the memory slave: transfer/size/response encodings and FSM states.
// AHB_MEM_ERR_EN adds the two-cycle ERROR response states.
package ahb_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

`ifdef AHB_MEM_ERR_EN
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} slv_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} slv_state_t;
`endif

   // Little-endian lane select for up to 8 byte lanes; lo must already be masked to the bus width.
   function automatic logic [7:0] lane_mask(input logic [2:0] lo, input logic [2:0] size,
                                            input logic [2:0] nbl);
      lane_mask = '0;
      for (int i = 0; i < 8; i++)
         if (size >= nbl || ((i >> size) == (int'(lo) >> size)))
            lane_mask[i] = 1'b1;
   endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-laned storage: one synchronous write port with byte enables, one combinational read port.
module ahb_mem_array #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   localparam int NB         = DATA_W / 8,
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic              hclk,
   input  logic              we,
   input  logic [NB-1:0]     be,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   for (genvar b = 0; b < NB; b++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge hclk)
         if (we && be[b])
            mem[waddr] <= wdata[8*b +: 8];

      assign rdata[8*b +: 8] = mem[raddr];
   end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-lite memory slave with WAIT_CYCLES wait states per transfer and pipelined address phases.
// Define AHB_MEM_ERR_EN to answer out-of-range/illegal accesses with an ERROR response.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int                 ADDR_W      = 32,
   parameter int                 DATA_W      = 32,
   parameter int                 DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
   parameter int                 WAIT_CYCLES = 2
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata
);

   localparam int         NB   = DATA_W / 8;
   localparam int         NBL  = $clog2(NB);
   localparam int         AW   = $clog2(DEPTH_WORDS);
   localparam logic [2:0] NBL3 = 3'(NBL);
   localparam logic [3:0] WC   = 4'(WAIT_CYCLES);

   slv_state_t        state;
   logic [3:0]        cnt;
   logic              wr_q;
   logic [NB-1:0]     be_q;
   logic [AW-1:0]     idx_q;

   logic              accept;
   logic [ADDR_W-1:0] off;
   logic [AW-1:0]     idx;
   logic [2:0]        lo;
   logic [7:0]        mask8;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] rdata;
   logic              we;
   logic              unused_ok;

   assign accept = hsel && hready && (htrans == TR_NONSEQ || htrans == TR_SEQ);
   assign off    = haddr - BASE_ADDR;
   assign idx    = off[NBL +: AW];
   assign lo     = 3'(haddr[NBL-1:0]);
   assign mask8  = lane_mask(lo, hsize, NBL3);
   assign be     = mask8[NB-1:0];

`ifdef AHB_MEM_ERR_EN
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS * NB);
   logic misalign, illegal, bad;
   assign misalign = |(lo & ~(3'h7 << hsize));
   assign illegal  = (hsize > NBL3) || misalign;
   assign bad      = (haddr < BASE_ADDR) || ({1'b0, off} >= SPAN) || illegal;
`endif

   assign unused_ok = ^{1'b0, hburst, off};

   // IDLE, DONE and ERR2 all present hreadyout=1, so each may take the next address phase.
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         wr_q      <= 1'b0;
         be_q      <= '0;
         idx_q     <= '0;
      end else begin
         case (state)
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state     <= ST_DONE;
                  hreadyout <= 1'b1;
               end
            end
`ifdef AHB_MEM_ERR_EN
            ST_ERR1: begin
               state     <= ST_ERR2;
               hreadyout <= 1'b1;
            end
`endif
            default: begin
               state     <= ST_IDLE;
               hreadyout <= 1'b1;
               hresp     <= HRESP_OKAY;
               if (accept) begin
                  idx_q <= idx;
                  be_q  <= be;
                  wr_q  <= hwrite;
`ifdef AHB_MEM_ERR_EN
                  if (bad) begin
                     state     <= ST_ERR1;
                     hreadyout <= 1'b0;
                     hresp     <= HRESP_ERROR;
                     wr_q      <= 1'b0;
                  end else
`endif
                  if (WAIT_CYCLES == 0) begin
                     state <= ST_DONE;
                  end else begin
                     state     <= ST_WAIT;
                     cnt       <= WC;
                     hreadyout <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // Commit happens on the edge leaving DONE, so a read accepted on that edge sees the new data.
   assign we     = (state == ST_DONE) && wr_q;
   assign hrdata = (state == ST_DONE && !wr_q) ? rdata : '0;

   ahb_mem_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .hclk  (hclk),
      .we    (we),
      .be    (be_q),
      .waddr (idx_q),
      .wdata (hwdata),
      .raddr (idx_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: a WAIT_CYCLES=2 slave and a WAIT_CYCLES=0 slave share one driven bus.
// Table vectors cover sized writes/reads; hand sequences cover pipelining, reset, IDLE/BUSY, errors.
module tb_ahb_mem_slave;
   import ahb_pkg::*;

   logic        hclk, hrst;
   logic        hsel, hwrite, dsel;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic        hro0, hresp0, hro1, hresp1;
   logic [31:0] hrdata0, hrdata1;
   logic        hsel0, hsel1, hro_m, hresp_m;
   logic [31:0] hrdata_m;

   int nvec = 0;
   int nmis = 0;

   assign hsel0    = hsel & ~dsel;
   assign hsel1    = hsel &  dsel;
   assign hro_m    = dsel ? hro1    : hro0;
   assign hresp_m  = dsel ? hresp1  : hresp0;
   assign hrdata_m = dsel ? hrdata1 : hrdata0;

   ahb_mem_slave #(.WAIT_CYCLES(2)) u_w2 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(hro0), .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0));

   ahb_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
      .hclk(hclk), .hrst(hrst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(hro1), .hreadyout(hro1), .hresp(hresp1), .hrdata(hrdata1));

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One isolated transfer; returns data/response seen on the completing cycle and the stall count.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output int waits,
                       output logic resp0, output logic resp);
      @(negedge hclk);
      hsel = 1'b1; htrans = TR_NONSEQ; hwrite = wr; haddr = a; hsize = sz;
      @(posedge hclk);
      @(negedge hclk);
      htrans = TR_IDLE; hwdata = wd;
      waits = 0;
      resp0 = hresp_m;
      while (!hro_m && waits < 20) begin
         waits++;
         @(negedge hclk);
      end
      rd   = hrdata_m;
      resp = hresp_m;
      @(posedge hclk);
   endtask

   typedef struct {
      bit          d;
      bit          wr;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t        tv[$];
   logic [31:0] rd;
   int          waits;
   logic        r0, r1;
   logic [31:0] pipe_exp [4];

   initial begin
      hrst = 1'b1; hsel = 1'b0; dsel = 1'b0; haddr = '0; hwdata = '0;
      htrans = TR_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; hburst = 3'b000;

      tv.push_back('{0, 1, 32'h10,  HSIZE_WORD, 32'hDEADBEEF, 32'h0});
      tv.push_back('{0, 0, 32'h10,  HSIZE_WORD, 32'h0,        32'hDEADBEEF});
      tv.push_back('{0, 1, 32'h10,  HSIZE_WORD, 32'h11223344, 32'h0});
      tv.push_back('{0, 1, 32'h13,  HSIZE_BYTE, 32'hAA5A5A5A, 32'h0});
      tv.push_back('{0, 0, 32'h10,  HSIZE_WORD, 32'h0,        32'hAA223344});
      tv.push_back('{0, 1, 32'h10,  HSIZE_HALF, 32'h9999BEEF, 32'h0});
      tv.push_back('{0, 0, 32'h10,  HSIZE_WORD, 32'h0,        32'hAA22BEEF});
      tv.push_back('{0, 1, 32'h14,  HSIZE_WORD, 32'h00000000, 32'h0});
      tv.push_back('{0, 1, 32'h16,  HSIZE_HALF, 32'hC0DE1234, 32'h0});
      tv.push_back('{0, 0, 32'h14,  HSIZE_WORD, 32'h0,        32'hC0DE0000});
      tv.push_back('{0, 1, 32'h11,  HSIZE_BYTE, 32'h00007700, 32'h0});
      tv.push_back('{0, 0, 32'h10,  HSIZE_WORD, 32'h0,        32'hAA2277EF});
      tv.push_back('{0, 1, 32'hFFC, HSIZE_WORD, 32'h600DF00D, 32'h0});
      tv.push_back('{0, 0, 32'hFFC, HSIZE_WORD, 32'h0,        32'h600DF00D});
      tv.push_back('{1, 1, 32'h0,   HSIZE_WORD, 32'hA0A0A0A0, 32'h0});
      tv.push_back('{1, 1, 32'h4,   HSIZE_WORD, 32'hB1B1B1B1, 32'h0});
      tv.push_back('{1, 1, 32'h8,   HSIZE_WORD, 32'hC2C2C2C2, 32'h0});
      tv.push_back('{1, 1, 32'hC,   HSIZE_WORD, 32'hD3D3D3D3, 32'h0});
      tv.push_back('{1, 0, 32'h8,   HSIZE_WORD, 32'h0,        32'hC2C2C2C2});
      pipe_exp = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

      // Reset state
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      chk("rst_hreadyout_w2", {31'b0, hro0}, 32'd1);
      chk("rst_hresp_w2",     {31'b0, hresp0}, 32'd0);
      chk("rst_hrdata_w2",    hrdata0, 32'd0);
      chk("rst_hreadyout_w0", {31'b0, hro1}, 32'd1);
      hrst = 1'b0;

      foreach (tv[i]) begin
         dsel = tv[i].d;
         xfer(tv[i].wr, tv[i].a, tv[i].sz, tv[i].wd, rd, waits, r0, r1);
         chk($sformatf("vec%0d_waits", i), 32'(waits), tv[i].d ? 32'd0 : 32'd2);
         chk($sformatf("vec%0d_hresp", i), {31'b0, r1}, 32'd0);
         if (!tv[i].wr)
            chk($sformatf("vec%0d_hrdata", i), rd, tv[i].exp);
      end

      // Zero-wait pipelined SEQ reads: one result per cycle, hreadyout never drops
      dsel = 1'b1;
      @(negedge hclk);
      hsel = 1'b1; htrans = TR_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h0;
      hburst = 3'b011;
      for (int k = 0; k < 4; k++) begin
         @(posedge hclk);
         @(negedge hclk);
         chk($sformatf("pipe%0d_hreadyout", k), {31'b0, hro_m}, 32'd1);
         chk($sformatf("pipe%0d_hrdata", k), hrdata_m, pipe_exp[k]);
         if (k < 3) begin
            htrans = TR_SEQ; haddr = 32'(4 * (k + 1));
         end else begin
            htrans = TR_IDLE;
         end
      end
      @(posedge hclk);
      hburst = 3'b000;

      // Write then read of the same word, read address phase overlapping the write's data phase
      dsel = 1'b0;
      @(negedge hclk);
      hsel = 1'b1; htrans = TR_NONSEQ; hwrite = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD;
      @(posedge hclk);
      @(negedge hclk);
      hwdata = 32'h5EED1234; htrans = TR_NONSEQ; hwrite = 1'b0;
      waits = 0;
      while (!hro_m && waits < 20) begin waits++; @(negedge hclk); end
      chk("b2b_wr_waits", 32'(waits), 32'd2);
      @(posedge hclk);
      @(negedge hclk);
      htrans = TR_IDLE;
      waits = 0;
      while (!hro_m && waits < 20) begin waits++; @(negedge hclk); end
      chk("b2b_rd_waits", 32'(waits), 32'd2);
      chk("b2b_rd_hrdata", hrdata_m, 32'h5EED1234);
      chk("b2b_rd_hresp", {31'b0, hresp_m}, 32'd0);
      @(posedge hclk);

      // Reset during a write's wait state drops the write
      xfer(1'b1, 32'h30, HSIZE_WORD, 32'h13572468, rd, waits, r0, r1);
      @(negedge hclk);
      hsel = 1'b1; htrans = TR_NONSEQ; hwrite = 1'b1; haddr = 32'h30;
      @(posedge hclk);
      @(negedge hclk);
      htrans = TR_IDLE; hwdata = 32'hFFFFFFFF;
      chk("rstwait_stalled", {31'b0, hro_m}, 32'd0);
      hrst = 1'b1;
      #1;
      chk("rstwait_hreadyout", {31'b0, hro_m}, 32'd1);
      chk("rstwait_hresp", {31'b0, hresp_m}, 32'd0);
      chk("rstwait_hrdata", hrdata_m, 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      hrst = 1'b0;
      xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, rd, waits, r0, r1);
      chk("rstwait_after_waits", 32'(waits), 32'd2);
      chk("rstwait_after_data", rd, 32'h13572468);

      // IDLE then BUSY with hsel high: zero-wait OKAY, no write
      @(negedge hclk);
      hsel = 1'b1; htrans = TR_IDLE; hwrite = 1'b1; haddr = 32'h30; hwdata = 32'h0;
      @(posedge hclk);
      @(negedge hclk);
      chk("idle_hreadyout", {31'b0, hro_m}, 32'd1);
      chk("idle_hresp", {31'b0, hresp_m}, 32'd0);
      htrans = TR_BUSY;
      @(posedge hclk);
      @(negedge hclk);
      chk("busy_hreadyout", {31'b0, hro_m}, 32'd1);
      chk("busy_hresp", {31'b0, hresp_m}, 32'd0);
      htrans = TR_IDLE;
      @(posedge hclk);
      @(negedge hclk);
      chk("busy_after_hreadyout", {31'b0, hro_m}, 32'd1);
      xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, rd, waits, r0, r1);
      chk("idlebusy_nowrite", rd, 32'h13572468);

      // Access just past the top of storage
      xfer(1'b1, 32'h0, HSIZE_WORD, 32'h01234567, rd, waits, r0, r1);
      xfer(1'b1, 32'h1000, HSIZE_WORD, 32'hCAFEF00D, rd, waits, r0, r1);
`ifdef AHB_MEM_ERR_EN
      chk("oob_stall_cycles", 32'(waits), 32'd1);
      chk("oob_hresp_cycle1", {31'b0, r0}, 32'd1);
      chk("oob_hresp_cycle2", {31'b0, r1}, 32'd1);
      xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, waits, r0, r1);
      chk("oob_word0_kept", rd, 32'h01234567);
`else
      chk("oob_stall_cycles", 32'(waits), 32'd2);
      chk("oob_hresp", {31'b0, r1}, 32'd0);
      xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, waits, r0, r1);
      chk("oob_word0_wrapped", rd, 32'hCAFEF00D);
`endif
      chk("final_hresp", {31'b0, r1}, 32'd0);

      hsel = 1'b0;
      repeat (2) @(posedge hclk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 32, HADDR width in bits.
REQ-002 Parameter DATA_W, default 32, HWDATA/HRDATA width in bits (32 or 64).
REQ-003 Parameter DEPTH_WORDS, default 1024, number of DATA_W-bit storage words (power of two).
REQ-004 Parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 Parameter WAIT_CYCLES, default 2, wait states inserted per transfer (0..15).
REQ-006 hclk  input  1  clock; all logic on the rising edge.
REQ-007 hrst  input  1  reset, asynchronous and active-high.
REQ-008 hsel, haddr, htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hwdata[DATA_W], hready  input  AHB-lite slave inputs.
REQ-009 hreadyout  output  1  transfer-complete / stall; hresp  output  1  OKAY=0, ERROR=1; hrdata  output  DATA_W  read data.

Function
REQ-010 The block SHALL accept an address phase only when hsel=1, hready=1 and htrans is NONSEQ or SEQ; IDLE and BUSY SHALL get a zero-wait OKAY.
REQ-011 The accepted address, hwrite and hsize SHALL be latched; the FSM SHALL be IDLE -> WAIT (when WAIT_CYCLES>0) -> DONE -> IDLE, or DONE directly when WAIT_CYCLES=0.
REQ-012 In WAIT, hreadyout SHALL be 0 for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded at acceptance.
REQ-013 In DONE, hreadyout SHALL be 1 and hresp 0; read data SHALL be driven on hrdata in that cycle.
REQ-014 Writes SHALL commit hwdata at the DONE edge, using byte lanes from hsize and haddr low bits (little-endian); untouched bytes SHALL be kept.
REQ-015 Transfers SHALL pipeline: a new address phase accepted in the DONE cycle SHALL start its own sequence with no idle cycle between them.
REQ-016 Word index SHALL be (haddr-BASE_ADDR)>>log2(DATA_W/8), truncated to log2(DEPTH_WORDS) bits.
REQ-017 hsize wider than DATA_W, or haddr not aligned to hsize, SHALL be flagged as an illegal access.
REQ-018 hburst SHALL be ignored; every beat is handled as a single transfer.
REQ-019 Back-to-back write then read of the same address SHALL return the newly written data.

Reset
REQ-020 While hrst=1: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, counter=0.
REQ-021 A transfer in progress when reset is asserted SHALL be dropped and SHALL NOT write storage; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-022 Macro AHB_MEM_ERR_EN defined: accesses below BASE_ADDR, beyond BASE_ADDR+DEPTH_WORDS*DATA_W/8-1, or illegal per REQ-017 SHALL skip wait states and return a two-cycle ERROR (cycle 1 hreadyout=0 hresp=1; cycle 2 hreadyout=1 hresp=1), with no write; states ERR1/ERR2 are added.
REQ-023 Macro undefined: such accesses SHALL wrap per REQ-016, complete with OKAY, and ERR states SHALL NOT exist.

Structure
REQ-024 Package ahb_pkg SHALL hold the htrans_t, hsize_t and hresp_t enums and the slave FSM state typedef.
REQ-025 Storage SHALL be a sub-module ahb_mem_array (one write port with byte-enables, one combinational read port, parameterised by DATA_W and DEPTH_WORDS).

Verification
REQ-026 WAIT_CYCLES=2, NONSEQ write 0xDEADBEEF to 0x10, then read 0x10 -> two hreadyout=0 cycles each, read hrdata=0xDEADBEEF, hresp=0.
REQ-027 hsize=byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
REQ-028 WAIT_CYCLES=0, four pipelined SEQ reads 0x0,0x4,0x8,0xC -> hreadyout stays 1, data returned on four consecutive cycles.
REQ-029 AHB_MEM_ERR_EN defined, DEPTH_WORDS=1024, write to 0x1000 -> hresp=1 for 2 cycles, hreadyout 0 then 1, later read of 0x0 is unchanged; without macro -> OKAY and word 0 is overwritten.
REQ-030 hrst asserted during a WAIT cycle of a write -> hreadyout=1 immediately, target word unchanged; after release, next transfer completes normally.
REQ-031 htrans=IDLE with hsel=1, then BUSY -> hreadyout=1, hresp=0, no storage change.
